// File: rtl/gpi_conditioner.sv
// gpi_conditioner: synchronises and debounces raw pad inputs for the GPIO
// block's GPI port. It also flags rising and falling edges of the debounced
// bits through a write-1-to-clear status register and a level interrupt.
// Register access uses the common valid/ready request/response bus.
module gpi_conditioner #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  input  logic             we_i,
  output logic [31:0]      data_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpi_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] gpi_q, gpi_d;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] tlast;
  logic [WIDTH-1:0] en_rise_q, en_rise_d, en_fall_q, en_fall_d;
  logic [WIDTH-1:0] stat_rise_q, stat_rise_d, stat_fall_q, stat_fall_d;
  logic [WIDTH-1:0] rise, fall, clr_rise, clr_fall;
  logic             irq_q;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      rdata;
  logic [15:0]      gpi16, en_rise16, en_fall16, stat_rise16, stat_fall16;
  logic             accept, wr;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

  assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;
  assign wr          = accept & we_i;

  assign rsp_valid_o = rsp_valid_q;
  assign data_o      = data_q;
  assign gpi_o       = gpi_q;
  assign irq_o       = irq_q;

  // A threshold of 0 behaves like 1, so the terminal count is T-1 with T>=1
  assign tlast = (thresh_q == '0) ? '0 : thresh_q - CNT_W'(1);

  // Two-flop synchroniser per pad bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: adopt the new level after T consecutive mismatching cycles
  always_comb begin
    gpi_d = gpi_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == gpi_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == tlast) begin
        gpi_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters and the clean output, plus its one-cycle history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpi_q  <= '0;
      prev_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      gpi_q  <= gpi_d;
      prev_q <= gpi_q;
      cnt_q  <= cnt_d;
    end
  end

  assign rise = gpi_q & ~prev_q;
  assign fall = ~gpi_q & prev_q;

  // Widen per-bit fields to the 16-bit register halves; unused bits read 0
  always_comb begin
    gpi16       = '0;
    en_rise16   = '0;
    en_fall16   = '0;
    stat_rise16 = '0;
    stat_fall16 = '0;
    gpi16[WIDTH-1:0]       = gpi_q;
    en_rise16[WIDTH-1:0]   = en_rise_q;
    en_fall16[WIDTH-1:0]   = en_fall_q;
    stat_rise16[WIDTH-1:0] = stat_rise_q;
    stat_fall16[WIDTH-1:0] = stat_fall_q;
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (addr_i[3:2])
      2'd0:    rdata = 32'(thresh_q);
      2'd1:    rdata = {en_fall16, en_rise16};
      2'd2:    rdata = {stat_fall16, stat_rise16};
      default: rdata = {16'h0000, gpi16};
    endcase
  end

  // Register writes and status update; a new edge outranks a same-cycle clear
  always_comb begin
    thresh_d  = thresh_q;
    en_rise_d = en_rise_q;
    en_fall_d = en_fall_q;
    clr_rise  = '0;
    clr_fall  = '0;
    if (wr) begin
      case (addr_i[3:2])
        2'd0: thresh_d = data_i[CNT_W-1:0];
        2'd1: begin
          en_rise_d = data_i[WIDTH-1:0];
          en_fall_d = data_i[16 +: WIDTH];
        end
        2'd2: begin
          clr_rise = data_i[WIDTH-1:0];
          clr_fall = data_i[16 +: WIDTH];
        end
        default: ;
      endcase
    end
    stat_rise_d = (stat_rise_q & ~clr_rise) | (rise & en_rise_q);
    stat_fall_d = (stat_fall_q & ~clr_fall) | (fall & en_fall_q);
  end

  // Response channel next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      data_d      = we_i ? '0 : rdata;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control/status registers, interrupt and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q    <= '0;
      en_rise_q   <= '0;
      en_fall_q   <= '0;
      stat_rise_q <= '0;
      stat_fall_q <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      thresh_q    <= thresh_d;
      en_rise_q   <= en_rise_d;
      en_fall_q   <= en_fall_d;
      stat_rise_q <= stat_rise_d;
      stat_fall_q <= stat_fall_d;
      irq_q       <= |{stat_rise_q, stat_fall_q};
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_gpi_conditioner.sv
// Bench for gpi_conditioner: directed stimulus, a behavioural reference
// model checked every cycle, and hand-computed literal expectations.
module tb_gpi_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_i, data_i, data_o;
  logic        we_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [15:0] pad_i, gpi_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  gpi_conditioner #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_i(addr_i), .data_i(data_i), .we_i(we_i), .data_o(data_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .pad_i(pad_i), .gpi_o(gpi_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a level is adopted once the last T synchronised samples
  // all disagree with it; edges, status and bus follow the register rules.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_gpi = '0, m_prev = '0;
  logic [15:0] m_er = '0, m_ef = '0, m_sr = '0, m_sf = '0, m_thr = '0;
  logic        m_irq = 1'b0, m_rv = 1'b0;
  logic [31:0] m_data = '0;
  logic [15:0] hist[$];
  logic [15:0] m_rise, m_fall, m_nxt, m_h, m_clr_r, m_clr_f;
  logic [31:0] m_rd;
  logic        m_acc, m_all;
  int          m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_gpi = '0; m_prev = '0;
      m_er = '0; m_ef = '0; m_sr = '0; m_sf = '0; m_thr = '0;
      m_irq = 1'b0; m_rv = 1'b0; m_data = '0;
      hist.delete();
    end else begin
      m_rise = m_gpi & ~m_prev;
      m_fall = ~m_gpi & m_prev;
      m_acc  = req_valid_i && (!m_rv || rsp_ready_i);
      case (addr_i[3:2])
        2'd0:    m_rd = {16'h0, m_thr};
        2'd1:    m_rd = {m_ef, m_er};
        2'd2:    m_rd = {m_sf, m_sr};
        default: m_rd = {16'h0, m_gpi};
      endcase
      hist.push_back(m_s2);
      if (hist.size() > 400) void'(hist.pop_front());
      m_t = (m_thr == 0) ? 1 : int'(m_thr);
      m_nxt = m_gpi;
      for (int i = 0; i < 16; i++) begin
        if (hist.size() >= m_t) begin
          m_all = 1'b1;
          for (int k = 0; k < m_t; k++) begin
            m_h = hist[hist.size() - 1 - k];
            if (m_h[i] == m_gpi[i]) m_all = 1'b0;
          end
          if (m_all) m_nxt[i] = ~m_gpi[i];
        end
      end
      m_irq = |{m_sf, m_sr};
      m_clr_r = '0; m_clr_f = '0;
      if (m_acc && we_i && addr_i[3:2] == 2'd2) begin
        m_clr_r = data_i[15:0];
        m_clr_f = data_i[31:16];
      end
      m_sr = (m_sr & ~m_clr_r) | (m_rise & m_er);
      m_sf = (m_sf & ~m_clr_f) | (m_fall & m_ef);
      if (m_acc && we_i && addr_i[3:2] == 2'd0) m_thr = data_i[15:0];
      if (m_acc && we_i && addr_i[3:2] == 2'd1) begin
        m_er = data_i[15:0];
        m_ef = data_i[31:16];
      end
      if (m_acc) begin
        m_rv = 1'b1;
        m_data = we_i ? 32'h0 : m_rd;
      end else if (rsp_ready_i) begin
        m_rv = 1'b0;
      end
      m_prev = m_gpi;
      m_gpi  = m_nxt;
      m_s2   = m_s1;
      m_s1   = pad_i;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_gpi", {16'h0, gpi_o}, {16'h0, m_gpi});
    chk("m_irq", {31'h0, irq_o}, {31'h0, m_irq});
    chk("m_rsp_valid", {31'h0, rsp_valid_o}, {31'h0, m_rv});
    chk("m_req_ready", {31'h0, req_ready_o}, {31'h0, (~m_rv | rsp_ready_i)});
    chk("m_data", data_o, m_data);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; data_i = d; we_i = 1'b1; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a; we_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    d = data_o;
  endtask

  logic [31:0] r;

  initial begin
    rst_n = 1'b0; pad_i = '0; addr_i = '0; data_i = '0; we_i = 1'b0;
    req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    cyc(2);
    chk("rst_gpi", {16'h0, gpi_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    rst_n = 1'b1; rsp_ready_i = 1'b1;
    cyc(2);

    // THRESH=0 step: gpi follows 3 cycles later
    pad_i = 16'h0001;
    cyc(2);
    chk("t1_gpi_at2", {16'h0, gpi_o}, 32'h0);
    cyc(1);
    chk("t1_gpi_at3", {16'h0, gpi_o}, 32'h1);
    rd(32'hC, r);
    chk("t1_state", r, 32'h1);
    chk("t1_irq", {31'h0, irq_o}, 32'h0);

    // THRESH=10: 9-cycle glitch filtered, 10-cycle pulse passes at cycle 12
    wr(32'h0, 32'd10);
    cyc(2);
    pad_i = 16'h0009; cyc(9);
    pad_i = 16'h0001; cyc(20);
    chk("t2_glitch9", {31'h0, gpi_o[3]}, 32'h0);
    pad_i = 16'h0009; cyc(10);
    pad_i = 16'h0001; cyc(1);
    chk("t2_pulse_c11", {31'h0, gpi_o[3]}, 32'h0);
    cyc(1);
    chk("t2_pulse_c12", {31'h0, gpi_o[3]}, 32'h1);
    cyc(30);
    chk("t2_settled", {16'h0, gpi_o}, 32'h1);

    // Edge interrupts and write-1-to-clear
    wr(32'h4, 32'h0001_0001);
    wr(32'h0, 32'd1);
    pad_i = 16'h0000; cyc(6);
    pad_i = 16'h0001; cyc(6);
    pad_i = 16'h0000; cyc(6);
    rd(32'h8, r);
    chk("t3_stat", r, 32'h0001_0001);
    chk("t3_irq", {31'h0, irq_o}, 32'h1);
    wr(32'h8, 32'h0000_0001);
    rd(32'h8, r);
    chk("t3_stat_clr_rise", r, 32'h0001_0000);
    chk("t3_irq_still", {31'h0, irq_o}, 32'h1);
    wr(32'h8, 32'h0001_0000);
    chk("t3_irq_same_cyc", {31'h0, irq_o}, 32'h1);
    cyc(1);
    chk("t3_irq_cleared", {31'h0, irq_o}, 32'h0);

    // Clear colliding with a new rising edge: set wins
    pad_i = 16'h0001; cyc(3);
    chk("t4_gpi", {16'h0, gpi_o}, 32'h1);
    wr(32'h8, 32'h0000_0001);
    rd(32'h8, r);
    chk("t4_set_wins", r, 32'h0000_0001);
    wr(32'h8, 32'h0000_0001);
    cyc(2);
    chk("t4_irq_off", {31'h0, irq_o}, 32'h0);

    // Backpressure then back-to-back responses
    rsp_ready_i = 1'b0;
    addr_i = 32'hC; we_i = 1'b0; req_valid_i = 1'b1;
    cyc(1);
    chk("t5_rv", {31'h0, rsp_valid_o}, 32'h1);
    chk("t5_rr", {31'h0, req_ready_o}, 32'h0);
    chk("t5_data", data_o, 32'h1);
    addr_i = 32'h4;
    cyc(3);
    chk("t5_data_hold", data_o, 32'h1);
    chk("t5_rv_hold", {31'h0, rsp_valid_o}, 32'h1);
    chk("t5_rr_hold", {31'h0, req_ready_o}, 32'h0);
    rsp_ready_i = 1'b1;
    cyc(1);
    chk("t5_b2b_en", data_o, 32'h0001_0001);
    addr_i = 32'h8;
    cyc(1);
    chk("t5_b2b_stat", data_o, 32'h0);
    addr_i = 32'h0;
    cyc(1);
    chk("t5_b2b_thr", data_o, 32'h1);
    chk("t5_b2b_rv", {31'h0, rsp_valid_o}, 32'h1);
    req_valid_i = 1'b0;
    cyc(1);
    chk("t5_rv_drop", {31'h0, rsp_valid_o}, 32'h0);

    // Reset mid-count, then full 2+100 latency from release
    wr(32'h0, 32'd100);
    pad_i = 16'h0002;
    cyc(52);
    rd(32'hC, r);
    chk("t6_pre_state", r, 32'h1);
    rsp_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gpi", {16'h0, gpi_o}, 32'h0);
    chk("t6_rst_irq", {31'h0, irq_o}, 32'h0);
    chk("t6_rst_data", data_o, 32'h0);
    chk("t6_rst_rv", {31'h0, rsp_valid_o}, 32'h0);
    chk("t6_rst_rr", {31'h0, req_ready_o}, 32'h1);
    cyc(3);
    rsp_ready_i = 1'b1;
    rst_n = 1'b1;
    wr(32'h0, 32'd100);
    cyc(100);
    chk("t6_gpi_at101", {16'h0, gpi_o}, 32'h0);
    cyc(1);
    chk("t6_gpi_at102", {16'h0, gpi_o}, 32'h2);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
